mem_bus_arbiter: RTL and testbench

- Parametrised memory-port arbiter placed between CH bus masters (CPU fetch/data ports, DMA, bench drivers) and the single-ported memory.
- Memory-side signalling uses the existing CPU/memory convention: Address, Din/Dout, RW (1=read, 0=write).
- Generalises the single-master CPU-to-memory hookup: configurable data/address width, master count and memory wait states, with round-robin fairness and a req/ack handshake per master.

---
 rtl/mem_bus_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_bus_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter giving CH bus masters turns on a single-ported memory.
// Each grant runs IDLE -> ACCESS (LAT+1 cycles) -> DONE (one-cycle ack).
module mem_bus_arbiter #(
  parameter int N   = 16,
  parameter int A   = 16,
  parameter int CH  = 2,
  parameter int LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CH-1:0]    req,
  input  logic [CH-1:0]    rw,
  input  logic [CH*A-1:0]  addr,
  input  logic [CH*N-1:0]  wdata,
  output logic [CH-1:0]    ack,
  output logic [N-1:0]     rdata,
  output logic [CH-1:0]    gnt,
  output logic             busy,
  output logic [A-1:0]     Address,
  output logic [N-1:0]     Dout,
  input  logic [N-1:0]     Din,
  output logic             RW
);

  localparam int PW = (CH > 1) ? $clog2(CH) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t        state, state_d;
  logic [PW-1:0] ptr, ptr_d, win, cand;
  logic [3:0]    cnt, cnt_d;
  logic [CH-1:0] ack_d, gnt_d;
  logic [N-1:0]  rdata_d, dout_d;
  logic [A-1:0]  addr_d;
  logic          busy_d, rw_d;

  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= CH) s = s - CH;
    return PW'(s);
  endfunction

  // Walk the offsets from the far end so the requester nearest to ptr wins.
  always_comb begin
    win  = '0;
    cand = '0;
    for (int k = CH - 1; k >= 0; k--) begin
      cand = wrap_add(ptr, k);
      if (req[cand]) win = cand;
    end
  end

  // NOTE: every signal is given its hold value before the case so that no
  // path leaves it unassigned; a missing default here would infer a latch.
  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    cnt_d   = cnt;
    ack_d   = '0;
    gnt_d   = gnt;
    busy_d  = busy;
    rdata_d = rdata;
    addr_d  = Address;
    dout_d  = Dout;
    rw_d    = RW;
    case (state)
      IDLE: begin
        if (|req) begin
          addr_d  = addr[int'(win)*A +: A];
          dout_d  = wdata[int'(win)*N +: N];
          rw_d    = rw[win];
          gnt_d   = CH'(1) << win;
          busy_d  = 1'b1;
          ptr_d   = wrap_add(win, 1);
          cnt_d   = '0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt == 4'(LAT)) begin
          if (RW) rdata_d = Din;
          ack_d   = gnt;
          // The write strobe ends with the access; DONE only signals completion.
          rw_d    = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt + 4'd1;
        end
      end
      DONE: begin
        gnt_d   = '0;
        busy_d  = 1'b0;
        rw_d    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      ptr     <= '0;
      cnt     <= '0;
      ack     <= '0;
      gnt     <= '0;
      busy    <= 1'b0;
      rdata   <= '0;
      Address <= '0;
      Dout    <= '0;
      RW      <= 1'b1;
    end else begin
      state   <= state_d;
      ptr     <= ptr_d;
      cnt     <= cnt_d;
      ack     <= ack_d;
      gnt     <= gnt_d;
      busy    <= busy_d;
      rdata   <= rdata_d;
      Address <= addr_d;
      Dout    <= dout_d;
      RW      <= rw_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: a transaction-level round-robin model
// predicts grant order, ack timing and read data; a monitor checks every cycle.
module tb_mem_bus_arbiter;

  localparam int N    = 16;
  localparam int A    = 16;
  localparam int CH   = 3;
  localparam int LAT  = 1;
  localparam int TURN = LAT + 3;

  typedef struct {
    logic         rw;
    logic [A-1:0] addr;
    logic [N-1:0] wdata;
  } txn_t;

  typedef struct {
    int           m;
    logic         rw;
    logic [A-1:0] addr;
    logic [N-1:0] wdata;
    logic [N-1:0] rdata;
    int           t;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [CH-1:0]   req = '0;
  logic [CH-1:0]   rw_v = '0;
  logic [CH*A-1:0] addr_v = '0;
  logic [CH*N-1:0] wdata_v = '0;
  logic [CH-1:0]   ack, gnt;
  logic [N-1:0]    rdata, Dout, Din;
  logic [A-1:0]    Address;
  logic            busy, RW;

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  bit   mon_en = 1'b1;
  exp_t sb[$];

  // reference model state
  int           ptr_m = 0;
  logic [N-1:0] last_rd = '0;
  logic [N-1:0] shadow [0:255];
  txn_t         stim [CH][3];
  int           sidx [CH];

  // memory device seen by the arbiter
  logic [N-1:0] mem [0:255];
  bit           wr_ok [0:255];
  int           wcnt = 0;

  mem_bus_arbiter #(.N(N), .A(A), .CH(CH), .LAT(LAT)) dut (
    .clk(clk), .reset(reset), .req(req), .rw(rw_v), .addr(addr_v), .wdata(wdata_v),
    .ack(ack), .rdata(rdata), .gnt(gnt), .busy(busy), .Address(Address),
    .Dout(Dout), .Din(Din), .RW(RW)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [N-1:0] init_val(input logic [7:0] a);
    return (a == 8'h10) ? 16'hBEEF : {8'hC3, a};
  endfunction

  function automatic logic [CH-1:0] oh(input int m);
    return CH'(1) << m;
  endfunction

  // Wait-state memory: a write commits on the last edge of its LAT+1 strobe edges.
  always_comb Din = wr_ok[Address[7:0]] ? mem[Address[7:0]] : init_val(Address[7:0]);
  always @(posedge clk) begin
    if (!RW) begin
      if (wcnt == LAT) begin
        mem[Address[7:0]]   <= Dout;
        wr_ok[Address[7:0]] <= 1'b1;
      end
      wcnt <= wcnt + 1;
    end else begin
      wcnt <= 0;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
  endtask

  // Monitor: per-cycle control/bus expectations from the scoreboard head; pops on ack.
  exp_t h;
  logic [CH-1:0] e_ack, e_gnt;
  logic e_busy, e_rw;
  bit in_win;
  always @(negedge clk) begin
    if (mon_en) begin
      e_ack = '0; e_gnt = '0; e_busy = 1'b0; e_rw = 1'b1; in_win = 1'b0;
      if (sb.size() > 0) begin
        h = sb[0];
        if (cyc >= h.t - LAT - 1 && cyc <= h.t) begin
          in_win = 1'b1;
          e_gnt  = oh(h.m);
          e_busy = 1'b1;
          if (cyc == h.t) e_ack = e_gnt;
          else            e_rw  = h.rw;
        end
      end
      check("ctrl{ack,gnt,busy,RW}", 64'({ack, gnt, busy, RW}), 64'({e_ack, e_gnt, e_busy, e_rw}));
      if (in_win) check("bus{Address,Dout}", 64'({Address, Dout}), 64'({h.addr, h.wdata}));
      if (ack != '0) begin
        if (sb.size() == 0) begin
          check("stray_ack", 64'(ack), 64'd0);
        end else begin
          h = sb.pop_front();
          check("ack_cycle", 64'(cyc), 64'(h.t));
          check("ack_master", 64'(ack), 64'(oh(h.m)));
          check("rdata", 64'(rdata), 64'(h.rdata));
        end
      end else if (sb.size() > 0 && cyc >= sb[0].t) begin
        h = sb.pop_front();
        check("ack_missing", 64'(ack), 64'(oh(h.m)));
      end
    end
  end

  task automatic drive(input int i, input txn_t tx);
    rw_v[i]           = tx.rw;
    addr_v[i*A +: A]  = tx.addr;
    wdata_v[i*N +: N] = tx.wdata;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((busy || sb.size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      fail_now("wait_idle");
      sb.delete();
    end
  endtask

  task automatic fill_random(input logic [CH-1:0] s, input int r);
    for (int i = 0; i < CH; i++)
      if (s[i])
        for (int j = 0; j < r; j++)
          stim[i][j] = '{rw: 1'($urandom_range(0, 1)), addr: A'($urandom_range(0, 15)),
                         wdata: N'($urandom)};
  endtask

  // Every master in s issues r transactions, re-requesting one cycle after each ack.
  task automatic run_round(input logic [CH-1:0] s, input int r);
    int t, budget, base, idx;
    logic [CH-1:0] rearm;
    txn_t tx;
    wait_idle();
    t = cyc + LAT + 2;
    for (int rep = 0; rep < r; rep++) begin
      base = ptr_m;
      for (int k = 0; k < CH; k++) begin
        idx = (base + k) % CH;
        if (s[idx]) begin
          tx = stim[idx][rep];
          if (tx.rw) last_rd = shadow[tx.addr[7:0]];
          else       shadow[tx.addr[7:0]] = tx.wdata;
          sb.push_back('{m: idx, rw: tx.rw, addr: tx.addr, wdata: tx.wdata, rdata: last_rd, t: t});
          t += TURN;
          ptr_m = (idx + 1) % CH;
        end
      end
    end
    for (int i = 0; i < CH; i++) begin
      sidx[i] = 0;
      if (s[i]) begin
        drive(i, stim[i][0]);
        req[i] = 1'b1;
      end
    end
    rearm  = '0;
    budget = r * $countones(s) * TURN + 10;
    while (req != '0 || rearm != '0) begin
      @(negedge clk);
      for (int i = 0; i < CH; i++) begin
        if (rearm[i]) begin
          drive(i, stim[i][sidx[i]]);
          req[i]   = 1'b1;
          rearm[i] = 1'b0;
        end else if (req[i] && ack[i]) begin
          req[i] = 1'b0;
          sidx[i]++;
          if (sidx[i] < r) rearm[i] = 1'b1;
        end
      end
      budget--;
      if (budget < 0) begin
        fail_now("round_timeout");
        req   = '0;
        rearm = '0;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    for (int a = 0; a < 256; a++) shadow[a] = init_val(8'(a));

    // reset state
    #2 reset = 1'b0;
    #10 check("reset_state", 64'({ack, gnt, busy, RW, rdata, Address, Dout}),
              64'({3'b000, 3'b000, 1'b0, 1'b1, 16'h0, 16'h0, 16'h0}));
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // idle hygiene
    repeat (20) begin
      @(negedge clk);
      check("idle", 64'({gnt, busy, ack, RW}), 64'({3'b000, 1'b0, 3'b000, 1'b1}));
    end

    // single read by master 1
    stim[1][0] = '{rw: 1'b1, addr: 16'h0010, wdata: 16'h0};
    run_round(3'b010, 1);

    // write then read back by master 0
    stim[0][0] = '{rw: 1'b0, addr: 16'h0022, wdata: 16'hA5A5};
    stim[0][1] = '{rw: 1'b1, addr: 16'h0022, wdata: 16'h0};
    run_round(3'b001, 2);

    // full contention, each master twice
    fill_random(3'b111, 2);
    run_round(3'b111, 2);

    // randomised rounds
    for (int n = 0; n < 30; n++) begin
      logic [CH-1:0] s;
      int r;
      s = CH'($urandom_range(1, (1 << CH) - 1));
      r = $urandom_range(1, 3);
      fill_random(s, r);
      run_round(s, r);
    end

    // reset during a write
    wait_idle();
    mon_en = 1'b0;
    drive(0, '{rw: 1'b0, addr: 16'h0040, wdata: 16'h1234});
    req[0] = 1'b1;
    @(posedge clk);
    #1 check("mw_grant{gnt,RW,busy}", 64'({gnt, RW, busy}), 64'({3'b001, 1'b0, 1'b1}));
    @(posedge clk);
    #1 check("mw_hold{gnt,RW}", 64'({gnt, RW}), 64'({3'b001, 1'b0}));
    #1 reset = 1'b0;
    #1 check("mw_abort{ack,gnt,busy,RW}", 64'({ack, gnt, busy, RW}), 64'({3'b000, 3'b000, 1'b0, 1'b1}));
    req[0] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("mw_noack", 64'(ack), 64'd0);
    end
    reset   = 1'b1;
    ptr_m   = 0;
    last_rd = '0;
    mon_en  = 1'b1;
    check("mw_mem_0040", 64'(wr_ok[8'h40] ? mem[8'h40] : init_val(8'h40)), 64'(shadow[8'h40]));

    // pointer restarts at 0 after reset
    fill_random(3'b111, 1);
    run_round(3'b111, 1);
    wait_idle();

    // memory contents against the model
    for (int a = 0; a < 8'h50; a++)
      check("mem_final", 64'(wr_ok[a] ? mem[a] : init_val(8'(a))), 64'(shadow[a]));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
